// File: rtl/cam_capture.sv
`default_nettype none
// ============================================================================
// Module      : cam_capture
// Description : Camera parallel-bus front end. Resynchronises pclk/href/vsync/
//               data into the clk domain, captures one frame per arm request
//               into a small FIFO and presents the bytes on a valid/ready
//               stream, with frame and line status.
// Revision    : 1.0 - initial release
// ============================================================================
module cam_capture #(
    parameter int ADDR_BITS = 4,
    parameter int LINE_BITS = 10,
    parameter int COL_BITS  = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           cam_data,
    input  logic                 cam_pclk,
    input  logic                 cam_href,
    input  logic                 cam_vsync,
    input  logic                 capture_en,
    output logic [7:0]           pix_data,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 frame_active,
    output logic                 frame_done,
    output logic                 overflow,
    output logic [LINE_BITS-1:0] line_count,
    output logic [COL_BITS-1:0]  col_count
);

    localparam int c_DEPTH = 1 << ADDR_BITS;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ARM     = 2'd1;
    localparam logic [1:0] c_SYNC    = 2'd2;
    localparam logic [1:0] c_CAPTURE = 2'd3;

    // Synchroniser stages
    logic       r_pclk_s1, r_pclk_s2, r_pclk_s3;
    logic       r_href_s1, r_href_s2, r_href_s3;
    logic       r_vs_s1, r_vs_s2, r_vs_s3;
    logic [7:0] r_data_s1, r_data_s2;

    // Control state
    logic [1:0]           r_state;
    logic                 r_frame_done;
    logic [LINE_BITS-1:0] r_line;
    logic [COL_BITS-1:0]  r_col;

    // FIFO
    logic [7:0]         r_mem [c_DEPTH];
    logic [ADDR_BITS:0] r_wr_ptr, r_rd_ptr;
    logic               r_overflow;

    logic                 w_pclk_rise, w_vs_rise, w_vs_fall, w_href_fall;
    logic                 w_arm, w_push_req, w_push_ok, w_pop;
    logic                 w_empty, w_full;
    logic [ADDR_BITS-1:0] w_wr_addr, w_rd_addr;

    assign w_pclk_rise = r_pclk_s2 & ~r_pclk_s3;
    assign w_vs_rise   = r_vs_s2 & ~r_vs_s3;
    assign w_vs_fall   = ~r_vs_s2 & r_vs_s3;
    assign w_href_fall = ~r_href_s2 & r_href_s3;

    assign w_wr_addr = r_wr_ptr[ADDR_BITS-1:0];
    assign w_rd_addr = r_rd_ptr[ADDR_BITS-1:0];
    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (w_wr_addr == w_rd_addr) &&
                       (r_wr_ptr[ADDR_BITS] != r_rd_ptr[ADDR_BITS]);

    // An arm request is only honoured from IDLE; it also flushes the FIFO
    assign w_arm      = (r_state == c_IDLE) && capture_en;
    assign w_push_req = (r_state == c_CAPTURE) && w_pclk_rise && r_href_s2;
    assign w_pop      = ~w_empty && pix_ready;
    // A pop in the same cycle frees the slot the push needs
    assign w_push_ok  = w_push_req && (~w_full || w_pop);

    assign pix_data     = r_mem[w_rd_addr];
    assign pix_valid    = ~w_empty;
    assign frame_active = (r_state == c_CAPTURE);
    assign frame_done   = r_frame_done;
    assign overflow     = r_overflow;
    assign line_count   = r_line;
    assign col_count    = r_col;

    // Two-flop resync of all camera inputs plus a third stage for edge detect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pclk_s1 <= 1'b0; r_pclk_s2 <= 1'b0; r_pclk_s3 <= 1'b0;
            r_href_s1 <= 1'b0; r_href_s2 <= 1'b0; r_href_s3 <= 1'b0;
            r_vs_s1   <= 1'b0; r_vs_s2   <= 1'b0; r_vs_s3   <= 1'b0;
            r_data_s1 <= 8'h00;
            r_data_s2 <= 8'h00;
        end else begin
            r_pclk_s1 <= cam_pclk;  r_pclk_s2 <= r_pclk_s1; r_pclk_s3 <= r_pclk_s2;
            r_href_s1 <= cam_href;  r_href_s2 <= r_href_s1; r_href_s3 <= r_href_s2;
            r_vs_s1   <= cam_vsync; r_vs_s2   <= r_vs_s1;   r_vs_s3   <= r_vs_s2;
            r_data_s1 <= cam_data;
            r_data_s2 <= r_data_s1;
        end
    end

    // Frame state machine with line/column counters and end-of-frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_IDLE;
            r_frame_done <= 1'b0;
            r_line       <= '0;
            r_col        <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (capture_en) begin
                        r_state <= c_ARM;
                        r_line  <= '0;
                        r_col   <= '0;
                    end
                end
                c_ARM: begin
                    // Edge-based: a vsync already high on entry is not a rise
                    if (w_vs_rise) r_state <= c_SYNC;
                end
                c_SYNC: begin
                    if (w_vs_fall) r_state <= c_CAPTURE;
                end
                c_CAPTURE: begin
                    // Column counts every byte offered, including dropped ones
                    if (w_push_req && (r_col != {COL_BITS{1'b1}})) begin
                        r_col <= r_col + 1'b1;
                    end
                    // Line close is evaluated even when the frame closes too
                    if (w_href_fall) begin
                        r_line <= r_line + 1'b1;
                        r_col  <= '0;
                    end
                    if (w_vs_rise) begin
                        r_frame_done <= 1'b1;
                        r_state      <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // FIFO pointers and sticky overflow; an accepted arm clears both
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else if (w_arm) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push_req && !w_push_ok) r_overflow <= 1'b1;
        end
    end

    // FIFO storage; contents are meaningless until written, so no reset
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[w_wr_addr] <= r_data_s2;
    end

endmodule
`default_nettype wire

// File: tb/tb_cam_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_cam_capture
// Description : Scoreboard bench for cam_capture. Stimulus drives the camera
//               bus and queues the bytes that must come out; a monitor pops
//               and compares on every accepted output byte.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cam_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  cam_data = 8'h00;
    logic        cam_pclk = 1'b0;
    logic        cam_href = 1'b0;
    logic        cam_vsync = 1'b0;
    logic        capture_en = 1'b0;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic        frame_active;
    logic        frame_done;
    logic        overflow;
    logic [9:0]  line_count;
    logic [10:0] col_count;

    int n_cmp = 0;
    int n_mis = 0;
    logic [7:0] exp_q [$];

    cam_capture #(.ADDR_BITS(4), .LINE_BITS(10), .COL_BITS(11)) dut (
        .clk(clk), .rst(rst),
        .cam_data(cam_data), .cam_pclk(cam_pclk), .cam_href(cam_href),
        .cam_vsync(cam_vsync), .capture_en(capture_en),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .frame_active(frame_active), .frame_done(frame_done),
        .overflow(overflow), .line_count(line_count), .col_count(col_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every accepted byte must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_mis++;
                $display("FAIL unexpected_byte: got 0x%0h expected none at %0t", pix_data, $time);
            end else begin
                check("pix_data", {24'h0, pix_data}, {24'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit expect_out);
        cam_data = d;
        cam_href = 1'b1;
        cam_pclk = 1'b0;
        cyc(4);
        cam_pclk = 1'b1;
        if (expect_out) exp_q.push_back(d);
        cyc(4);
    endtask

    task automatic end_line();
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        cyc(8);
    endtask

    task automatic start_frame(input bit junk);
        cam_vsync = 1'b0;
        cyc(8);
        capture_en = 1'b1;
        cyc(1);
        capture_en = 1'b0;
        if (junk) begin
            for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i), 1'b0);
            end_line();
        end
        cam_vsync = 1'b1;
        cyc(8);
        if (junk) begin
            for (int i = 0; i < 3; i++) send_byte(8'hF0 + 8'(i), 1'b0);
            end_line();
        end
        cam_vsync = 1'b0;
        cyc(8);
    endtask

    task automatic end_frame(input int exp_lines);
        bit found = 1'b0;
        cam_pclk = 1'b0;
        cam_href = 1'b0;
        cyc(4);
        cam_vsync = 1'b1;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (frame_done) found = 1'b1;
        end
        check("frame_done_seen", {31'h0, found}, 32'd1);
        check("line_count_at_done", {22'h0, line_count}, exp_lines);
        @(negedge clk);
        check("frame_done_width", {31'h0, frame_done}, 32'd0);
        check("frame_active_after", {31'h0, frame_active}, 32'd0);
        cyc(1);
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!pix_valid) break;
        end
        check("drained_valid", {31'h0, pix_valid}, 32'd0);
        check("drained_queue", exp_q.size(), 32'd0);
        cyc(1);
    endtask

    initial begin
        // Reset
        cyc(3);
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'h0, pix_valid}, 32'd0);
        check("rst_active", {31'h0, frame_active}, 32'd0);
        check("rst_done", {31'h0, frame_done}, 32'd0);
        check("rst_overflow", {31'h0, overflow}, 32'd0);
        check("rst_line", {22'h0, line_count}, 32'd0);
        check("rst_col", {21'h0, col_count}, 32'd0);
        cyc(1);

        // Basic frame: 3 lines x 4 bytes, 0x10..0x1B
        pix_ready = 1'b1;
        start_frame(1'b0);
        @(negedge clk);
        check("active_in_capture", {31'h0, frame_active}, 32'd1);
        cyc(1);
        for (int l = 0; l < 3; l++) begin
            for (int b = 0; b < 4; b++) send_byte(8'h10 + 8'(l * 4 + b), 1'b1);
            end_line();
        end
        end_frame(3);
        check("basic_overflow", {31'h0, overflow}, 32'd0);
        drain();

        // Overflow: 20-byte line with consumer stalled
        pix_ready = 1'b0;
        start_frame(1'b0);
        for (int i = 0; i < 20; i++) send_byte(8'h40 + 8'(i), i < 16);
        @(negedge clk);
        check("ovf_col", {21'h0, col_count}, 32'd20);
        check("ovf_flag", {31'h0, overflow}, 32'd1);
        check("ovf_valid", {31'h0, pix_valid}, 32'd1);
        cyc(1);
        end_line();
        end_frame(1);
        pix_ready = 1'b1;
        drain();
        check("ovf_sticky", {31'h0, overflow}, 32'd1);

        // Activity outside CAPTURE must not reach the FIFO
        for (int i = 0; i < 3; i++) send_byte(8'hD0 + 8'(i), 1'b0);
        end_line();
        check("idle_no_bytes", {31'h0, pix_valid}, 32'd0);
        start_frame(1'b1);
        @(negedge clk);
        check("sync_no_bytes", {31'h0, pix_valid}, 32'd0);
        check("sync_col", {21'h0, col_count}, 32'd0);
        cyc(1);
        send_byte(8'h60, 1'b1);
        send_byte(8'h61, 1'b1);
        end_line();

        // Arm request during CAPTURE is ignored
        capture_en = 1'b1;
        cyc(1);
        capture_en = 1'b0;
        cyc(2);
        @(negedge clk);
        check("ignored_arm_active", {31'h0, frame_active}, 32'd1);
        check("ignored_arm_line", {22'h0, line_count}, 32'd1);
        cyc(1);
        for (int i = 0; i < 3; i++) send_byte(8'h62 + 8'(i), 1'b1);
        @(negedge clk);
        check("ignored_arm_col", {21'h0, col_count}, 32'd3);
        cyc(1);
        end_line();
        end_frame(2);
        drain();

        // Reset in the middle of a line
        pix_ready = 1'b0;
        start_frame(1'b0);
        send_byte(8'h70, 1'b1);
        send_byte(8'h71, 1'b1);
        end_line();
        for (int i = 0; i < 5; i++) send_byte(8'h72 + 8'(i), 1'b1);
        @(negedge clk);
        check("pre_rst_valid", {31'h0, pix_valid}, 32'd1);
        check("pre_rst_line", {22'h0, line_count}, 32'd1);
        cyc(1);
        rst = 1'b1;
        exp_q.delete();
        cyc(1);
        @(negedge clk);
        check("midrst_valid", {31'h0, pix_valid}, 32'd0);
        check("midrst_active", {31'h0, frame_active}, 32'd0);
        check("midrst_line", {22'h0, line_count}, 32'd0);
        check("midrst_col", {21'h0, col_count}, 32'd0);
        cam_href = 1'b0;
        cam_pclk = 1'b0;
        cyc(1);
        rst = 1'b0;
        pix_ready = 1'b1;
        cyc(2);
        start_frame(1'b0);
        for (int i = 0; i < 3; i++) send_byte(8'h80 + 8'(i), 1'b1);
        end_line();
        end_frame(1);
        drain();

        // Full FIFO with push and pop landing on the same cycle
        pix_ready = 1'b0;
        start_frame(1'b0);
        for (int i = 0; i < 16; i++) send_byte(8'h90 + 8'(i), 1'b1);
        @(negedge clk);
        check("full_valid", {31'h0, pix_valid}, 32'd1);
        check("full_no_ovf", {31'h0, overflow}, 32'd0);
        cyc(1);
        cam_data = 8'hA0;
        cam_href = 1'b1;
        cam_pclk = 1'b0;
        cyc(4);
        cam_pclk = 1'b1;
        exp_q.push_back(8'hA0);
        cyc(2);
        pix_ready = 1'b1;
        cyc(1);
        pix_ready = 1'b0;
        cyc(3);
        @(negedge clk);
        check("simul_no_ovf", {31'h0, overflow}, 32'd0);
        check("simul_col", {21'h0, col_count}, 32'd17);
        check("simul_queue", exp_q.size(), 32'd16);
        cyc(1);
        end_line();
        end_frame(1);
        pix_ready = 1'b1;
        drain();
        check("simul_ovf_final", {31'h0, overflow}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
